irq_arbiter: RTL

- Arbitrates the two external interrupt sources (key, ethernet) into the single interrupt request consumed by the processor fetch stage.
- Per source: detects the request edge, buffers the source's 32-bit data word and holds the request pending.
- Grants one source round-robin when the pipeline has no memory operation in flight.
- Tracks the in-service interrupt until the processor executes its return instruction (rti/rsi).
- Sits between the board-level interrupt sources and the processor top level.

---
 rtl/irq_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/irq_arbiter.sv
// Merges the key and ethernet interrupt sources into one request for the fetch stage.
// Each source has an edge detector, a one-deep pending buffer and a saturating drop counter.
module irq_arbiter #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              key_req,
   input  logic [DATA_W-1:0] key_data,
   input  logic              eth_req,
   input  logic [DATA_W-1:0] eth_data,
   input  logic              stall_interrupt,
   input  logic              ret,
   output logic              interrupt,
   output logic [DATA_W-1:0] interrupt_data,
   output logic              int_src,
   output logic              busy,
   output logic              key_ack,
   output logic              eth_ack,
   output logic [CNT_W-1:0]  key_drops,
   output logic [CNT_W-1:0]  eth_drops
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      SERVICE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // Index 0 is the key source, index 1 is the ethernet source.
   state_t            state_r;
   logic [1:0]        req_s;
   logic [1:0]        req_q_r;
   logic [1:0]        new_s;
   logic [1:0]        pend_r;
   logic [1:0]        clr_s;
   logic [DATA_W-1:0] din_s  [2];
   logic [DATA_W-1:0] buf_r  [2];
   logic [CNT_W-1:0]  drop_r [2];
   logic              grant_s;
   logic              win_s;
   logic              last_src_r;

   // Edge detection, grant decision and round-robin winner selection.
   always_comb begin
      req_s    = {eth_req, key_req};
      din_s[0] = key_data;
      din_s[1] = eth_data;
      new_s    = req_s & ~req_q_r;
      grant_s  = (state_r == IDLE) && (pend_r != 2'b00) && !stall_interrupt;
      if (pend_r == 2'b11) begin
         win_s = ~last_src_r;
      end else if (pend_r[1]) begin
         win_s = 1'b1;
      end else begin
         win_s = 1'b0;
      end
      clr_s = 2'b00;
      if (grant_s) begin
         clr_s[win_s] = 1'b1;
      end else begin
         clr_s = 2'b00;
      end
   end

   // Pending flags, data buffers and drop counters; a request arriving as its
   // pending bit is granted reloads the buffer instead of counting as a drop.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         req_q_r <= 2'b00;
         pend_r  <= 2'b00;
         for (int i = 0; i < 2; i++) begin
            buf_r[i]  <= '0;
            drop_r[i] <= '0;
         end
      end else begin
         req_q_r <= req_s;
         for (int i = 0; i < 2; i++) begin
            if (new_s[i] && (!pend_r[i] || clr_s[i])) begin
               pend_r[i] <= 1'b1;
               buf_r[i]  <= din_s[i];
            end else if (new_s[i]) begin
               if (drop_r[i] != CNT_MAX) begin
                  drop_r[i] <= drop_r[i] + 1'b1;
               end else begin
                  drop_r[i] <= drop_r[i];
               end
            end else if (clr_s[i]) begin
               pend_r[i] <= 1'b0;
            end else begin
               pend_r[i] <= pend_r[i];
            end
         end
      end
   end

   // Service state machine with registered handshake outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r        <= IDLE;
         last_src_r     <= 1'b1;
         interrupt      <= 1'b0;
         interrupt_data <= '0;
         int_src        <= 1'b0;
         busy           <= 1'b0;
         key_ack        <= 1'b0;
         eth_ack        <= 1'b0;
      end else begin
         interrupt <= 1'b0;
         key_ack   <= 1'b0;
         eth_ack   <= 1'b0;
         case (state_r)
            IDLE: begin
               if (grant_s) begin
                  state_r        <= ISSUE;
                  interrupt      <= 1'b1;
                  busy           <= 1'b1;
                  interrupt_data <= buf_r[win_s];
                  int_src        <= win_s;
                  last_src_r     <= win_s;
                  key_ack        <= ~win_s;
                  eth_ack        <= win_s;
               end else begin
                  state_r <= IDLE;
               end
            end
            ISSUE: begin
               state_r <= SERVICE;
            end
            SERVICE: begin
               if (ret) begin
                  state_r <= IDLE;
                  busy    <= 1'b0;
               end else begin
                  state_r <= SERVICE;
               end
            end
            default: begin
               state_r <= IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

   assign key_drops = drop_r[0];
   assign eth_drops = drop_r[1];

endmodule
